// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

  // Responder sequencing: accept in IDLE, count wait states, then pulse a response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
  localparam int unsigned DEF_DEPTH_LOG2  = 10;
  localparam int unsigned DEF_WAIT_CYCLES = 3;

  // Wait-state counter width; covers the legal WAIT_CYCLES range 0..15.
  localparam int unsigned CNT_W = 4;

  // Power-up content of word i: a small ramp so loads have recognisable data.
  function automatic logic [31:0] init_word(input int unsigned i);
    return (i < 63) ? 32'(i) : '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read.
// Contents are preset at power-up and are not touched by rst; only the read
// register is reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic                  rd_clr_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH-1:0][31:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = init_word(i);
    end
    return m;
  endfunction

  mem_t        mem_q = init_mem();
  logic [31:0] rdata_q;

  // Commit a store to the addressed word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register: captures the word on a load, zeroed for stores/errors, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_clr_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: valid/ready request, WAIT_CYCLES wait
// states, one-cycle response pulse, and a stall while an access is pending.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [32:0]      LIMIT     = 33'd4 << DEPTH_LOG2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             err_q;

  logic                  accept;
  logic                  cur_we;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  err;
  logic                  enter_resp;
  logic [31:0]           arr_rdata;

  assign accept = (state_q == IDLE) && req_valid;

  // With zero wait states the array is accessed on the accept edge itself,
  // before the request registers are loaded, so the live request is used there.
  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  // Wrapping subtraction folds addresses below BASE_ADDR into the error range.
  assign offset = cur_addr - BASE_ADDR;
  assign idx    = offset[DEPTH_LOG2+1:2];
  assign err    = {1'b0, offset} >= LIMIT;

  assign enter_resp = (state_d == RESP) && !rst;

  // Next-state and wait-state counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the request on accept so the MEM stage inputs may change afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Error flag is captured with the data and held until the next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (enter_resp) begin
      err_q <= err;
    end
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (enter_resp && cur_we && !err),
    .rd_en_i (enter_resp && !cur_we && !err),
    .rd_clr_i(enter_resp && (cur_we || err)),
    .addr_i  (idx),
    .wdata_i (cur_wdata),
    .rdata_o (arr_rdata)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = arr_rdata;
  assign resp_err   = err_q;
  assign stall      = accept || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 3 wait states and
// one with none; expected responses are queued at issue, popped on resp_valid.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        stall      [2];

  dmem_responder #(
    .BASE_ADDR  (32'd1024),
    .DEPTH_LOG2 (10),
    .WAIT_CYCLES(3)
  ) u_w3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[0]),
    .req_we    (req_we[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .req_ready (req_ready[0]),
    .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]),
    .resp_err  (resp_err[0]),
    .stall     (stall[0])
  );

  dmem_responder #(
    .BASE_ADDR  (32'd1024),
    .DEPTH_LOG2 (10),
    .WAIT_CYCLES(0)
  ) u_w0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[1]),
    .req_we    (req_we[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .req_ready (req_ready[1]),
    .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]),
    .resp_err  (resp_err[1]),
    .stall     (stall[1])
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic push(input int d, input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // {stall, resp_valid, req_ready}
  function automatic logic [31:0] flags(input int d);
    return {29'd0, stall[d], resp_valid[d], req_ready[d]};
  endfunction

  // Monitor for the 3-wait-state instance.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid[0]) begin
      if (exp_q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w3_unexpected_resp: got resp_valid=1 required none");
      end else begin
        e = exp_q0.pop_front();
        chk("w3_rdata", resp_rdata[0], e.rdata);
        chk("w3_err", {31'd0, resp_err[0]}, {31'd0, e.err});
      end
    end
  end

  // Monitor for the zero-wait-state instance.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid[1]) begin
      if (exp_q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w0_unexpected_resp: got resp_valid=1 required none");
      end else begin
        e = exp_q1.pop_front();
        chk("w0_rdata", resp_rdata[1], e.rdata);
        chk("w0_err", {31'd0, resp_err[1]}, {31'd0, e.err});
      end
    end
  end

  // Issue one request, waiting (bounded) for req_ready; returns at posedge+1 after accept.
  task automatic issue(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
    int n = 0;
    push(d, erd, eerr);
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    @(negedge clk);
    while (!req_ready[d] && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!req_ready[d]) begin
      failures++;
      $display("FAIL accept_timeout: got req_ready=0 required 1 within 50 cycles");
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
  endtask

  // Wait (bounded) until every queued response has been seen.
  task automatic drain(input int d);
    int n = 0;
    while (qsize(d) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qsize(d) != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending responses required 0", qsize(d));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_flags", flags(d), 32'b001);
      chk("reset_rdata", resp_rdata[d], 32'd0);
      chk("reset_err", {31'd0, resp_err[d]}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Load word 5 with 3 wait states: stall 4 cycles, response in c+4.
    push(0, 32'd5, 1'b0);
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'd1044;
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t1_accept_flags", flags(0), 32'b101);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_wait_flags", flags(0), 32'b100);
    end
    @(negedge clk);
    chk("t1_resp_flags", flags(0), 32'b010);
    @(negedge clk);
    chk("t1_idle_flags", flags(0), 32'b001);
    chk("t1_rdata_hold", resp_rdata[0], 32'd5);
    @(posedge clk);
    #1;

    // Store then load, including a misaligned load of the same word.
    issue(0, 1'b1, 32'd1064, 32'hDEADBEEF, 32'd0, 1'b0);
    issue(0, 1'b0, 32'd1064, 32'd0, 32'hDEADBEEF, 1'b0);
    issue(0, 1'b0, 32'd1066, 32'd0, 32'hDEADBEEF, 1'b0);
    drain(0);

    // Out-of-range below and above; errored store must not land in word 1023.
    issue(0, 1'b0, 32'd1020, 32'd0, 32'd0, 1'b1);
    issue(0, 1'b0, 32'd5120, 32'd0, 32'd0, 1'b1);
    issue(0, 1'b1, 32'd1020, 32'h55AA55AA, 32'd0, 1'b1);
    issue(0, 1'b0, 32'd5116, 32'd0, 32'd0, 1'b0);
    issue(0, 1'b0, 32'd1272, 32'd0, 32'd62, 1'b0);
    issue(0, 1'b0, 32'd1044, 32'd0, 32'd5, 1'b0);
    drain(0);

    // Reset in the 2nd wait cycle of a store aborts it.
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'd1036;
    req_wdata[0] = 32'hCAFEF00D;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_rst_flags", flags(0), 32'b001);
    chk("t4_rst_rdata", resp_rdata[0], 32'd0);
    chk("t4_rst_err", {31'd0, resp_err[0]}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("t4_no_resp", {31'd0, resp_valid[0]}, 32'd0);
    end
    @(posedge clk);
    #1;
    issue(0, 1'b0, 32'd1036, 32'd0, 32'd3, 1'b0);
    drain(0);

    // Request inputs change during WAIT; the latched store must win.
    push(0, 32'd0, 1'b0);
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'd1124;
    req_wdata[0] = 32'h12345678;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'd1224;
    req_wdata[0] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'd1228;
    @(posedge clk);
    #1 req_addr[0] = 32'd1232;
    @(negedge clk);
    chk("t5_wait_flags", flags(0), 32'b100);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    drain(0);
    issue(0, 1'b0, 32'd1124, 32'd0, 32'h12345678, 1'b0);
    issue(0, 1'b0, 32'd1224, 32'd0, 32'd50, 1'b0);
    issue(0, 1'b0, 32'd1228, 32'd0, 32'd51, 1'b0);
    issue(0, 1'b0, 32'd1232, 32'd0, 32'd52, 1'b0);
    drain(0);

    // Zero wait states: response next cycle, back-to-back accept in next IDLE.
    push(1, 32'd2, 1'b0);
    push(1, 32'd62, 1'b0);
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'd1032;
    req_valid[1] = 1'b1;
    @(negedge clk);
    chk("t6_accept_flags", flags(1), 32'b101);
    @(posedge clk);
    #1 req_addr[1] = 32'd1272;
    @(negedge clk);
    chk("t6_resp_flags", flags(1), 32'b010);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_idle_flags", flags(1), 32'b101);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t6_resp2_flags", flags(1), 32'b010);
    @(posedge clk);
    #1;
    drain(1);
    issue(1, 1'b1, 32'd1040, 32'hAAAA0001, 32'd0, 1'b0);
    issue(1, 1'b0, 32'd1040, 32'd0, 32'hAAAA0001, 1'b0);
    issue(1, 1'b0, 32'd1276, 32'd0, 32'd0, 1'b0);
    issue(1, 1'b0, 32'd1020, 32'd0, 32'd0, 1'b1);
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder answering load/store requests from the pipeline MEM stage over a valid/ready handshake, with a parameterised number of wait states. Maps byte addresses onto a word-organised array, commits stores, returns load data with a one-cycle response pulse and drives a stall so the pipeline holds while an access is outstanding. Sits between the MEM stage and the MEM/WB pipeline register.

## Interface
- BASE_ADDR, 32'd1024: byte address of word 0.
- DEPTH_LOG2, 10: log2 of word count (1024 words).
- WAIT_CYCLES, 3: wait states between accept and response; 0..15 legal.
- Reset and clock: rst, synchronous, active-high; clock clk.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present; held stable by MEM stage until accepted.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  out-of-range access, valid with resp_valid.
- stall  out  1  pipeline freeze request.

## Operation
- FSM states IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch we/addr/wdata, cnt <= WAIT_CYCLES; next WAIT, or RESP if WAIT_CYCLES==0.
- WAIT: cnt decrements each cycle; on edge where cnt==1, next RESP.
- RESP: resp_valid=1 for exactly one cycle; next IDLE unconditionally.
- Address: offset = req_addr - BASE_ADDR (32-bit, wraps); index = offset[DEPTH_LOG2+1:2]; addr[1:0] ignored.
- Range: err = offset >= (4 << DEPTH_LOG2), unsigned; covers addresses below BASE_ADDR via wrap.
- Store: array[index] <= wdata on the edge entering RESP, only if !err. Load: resp_rdata registered from array[index] on the same edge; 0 if err.
- stall = (IDLE & req_valid) | WAIT. Low in RESP so pipeline captures response and advances.
- Requests in WAIT/RESP are ignored (req_ready=0); not queued.
- Array contents not affected by rst; simulation init word i = i for i<63, else 0.

## Timing
- Reset values: state IDLE, cnt 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, stall = req_valid (combinational from IDLE).
- Accept in cycle c (req_valid & req_ready) -> resp_valid in cycle c+WAIT_CYCLES+1.
- Minimum request spacing: WAIT_CYCLES+2 cycles (next accept earliest in IDLE after RESP).
- Load after store to same index sees new data.
- rst mid-WAIT: transaction aborted, no write committed, no resp_valid. rst during RESP: write already committed, pulse cut.
- resp_rdata/resp_err hold their value until next RESP (or rst).

## Structure
- Package dmem_pkg: state enum (IDLE, WAIT, RESP), default BASE_ADDR, DEPTH_LOG2, WAIT_CYCLES width constant.
- One sub-module: dmem_array — single-port 2^DEPTH_LOG2 x 32 array, synchronous write-enable, synchronous registered read, init block.
- FSM, counter, address mapping and range check in dmem_responder.

## Test plan
- Load addr 1024+4*5, WAIT_CYCLES=3 -> stall high 4 cycles from request, resp_valid in cycle c+4, resp_rdata=5, resp_err=0.
- Store 0xDEADBEEF to 1024+40 then load same -> second resp_rdata=0xDEADBEEF; load 1024+42 (misaligned) -> 0xDEADBEEF.
- Load addr 1020 and addr 1024+4096 -> resp_err=1, resp_rdata=0; store to 1020 leaves all words unchanged.
- WAIT_CYCLES=0: load 1024+8 -> resp_valid cycle after accept, rdata=2; req_ready low in RESP, back-to-back request accepted in next IDLE cycle.
- Store to 1024+12 with rst asserted in 2nd WAIT cycle -> no resp_valid, outputs at reset values, later load of 1024+12 returns 3.
- Toggle req_addr/req_wdata during WAIT -> ignored; response reflects latched request.
